pot_spi_rx: RTL and testbench
=============================

Name: pot_spi_rx

Overview:
- SPI responder that decodes the 16-bit digital-potentiometer command frames sent by the pot-write path: sync_n low, MSB first, two bytes per frame.
- Models the pot's RDAC register and control register so that loopback self-test and bench checking can confirm what the pot would hold.
- Sits beside the pot SPI lines, fed by the same SPI_CLK/SYNC/DIN nets, and runs on the system clk.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer (min 2).
- RDAC_RESET, 10'h200, RDAC value after reset or after a reset command (midscale).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- spi_clk  input  1  SPI clock from master, idle low (mode 0).
- sync_n  input  1  frame select, active low.
- din  input  1  serial data from master.
- frame_valid  output  1  one-cycle pulse: a well-formed 16-bit frame was decoded.
- frame_err  output  1  one-cycle pulse: frame closed with a bit count other than 16.
- frame_data  output  16  raw last good frame.
- cmd  output  4  frame_data[13:10] of last good frame.
- rdac  output  10  modelled RDAC register.
- ctrl  output  2  modelled control register; ctrl[1] = RDAC write enable.
- wr_blocked  output  1  one-cycle pulse: RDAC write refused because ctrl[1]=0.

Behaviour:
- Input sync: spi_clk, sync_n and din each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized copies against a one-cycle-delayed copy.
  - din is sampled from the same delayed stage as the edge detect.
- Input timing: each spi_clk phase must be ≥2 clk periods; operation below that is undefined.
- Reset values:
  - frame_valid=0, frame_err=0, wr_blocked=0.
  - frame_data=0, cmd=0.
  - rdac=RDAC_RESET, ctrl=0.
  - state=IDLE, shift reg=0, bit count=0.
- State IDLE:
  - Waits for a sync_n falling edge, then clears the bit count and shift reg and moves to SHIFT.
  - spi_clk edges are ignored.
- State SHIFT:
  - On each spi_clk rising edge, shift din into bit 0 (MSB first) and increment the count.
  - The count saturates at 17.
  - A sync_n rising edge moves to CHECK.
- State CHECK (one cycle), then always back to IDLE:
  - count==16: pulse frame_valid, latch frame_data and cmd, and apply the command.
  - Any other count (0–15 or saturated 17): pulse frame_err. frame_data, cmd, rdac and ctrl are unchanged.
- Command decode on frame_data; bits [15:14] must be 00, otherwise the frame is ignored but frame_valid still pulses.
  - cmd 4'h0: NOP.
  - cmd 4'h1: write RDAC.
    - ctrl[1]=1: rdac <= data[9:0].
    - ctrl[1]=0: rdac unchanged, wr_blocked pulses in the same cycle as frame_valid.
  - cmd 4'h4: reset; rdac <= RDAC_RESET, ctrl <= 0. Matches frame 16'h1000.
  - cmd 4'h6: write control; ctrl <= data[1:0]. Frame 16'h1802 sets ctrl=2'b10.
  - Any other cmd: no register change.
- Update timing: rdac, ctrl, frame_data and cmd update in the same clk edge that raises frame_valid.
- Latency: frame_valid asserts SYNC_STAGES+2 clk cycles after the raw sync_n rising edge.
- sync_n falling edge while in CHECK: a frame starting in that cycle is missed. The master must hold sync_n high ≥2 clk between frames.
- sync_n falling edge while in SHIFT (a glitch) is impossible without a prior rise; no special handling.
- reset asserted mid-frame: the partial frame is discarded, all registers return to reset values, and no pulse is emitted. A frame already in progress when reset deasserts is not captured; the block waits for the next sync_n fall.
- Outputs are pulses only; no handshake or backpressure.

Test Plan:
- After reset, send 16'h1000 then 16'h1802 -> two frame_valid pulses, no frame_err. After the second frame: ctrl=2'b10, rdac=10'h200, cmd=4'h6.
- With ctrl=2'b10, send 16'h0523 -> frame_valid, cmd=4'h1, rdac=10'h123. Then send 16'h07FF -> rdac=10'h3FF.
- From reset (ctrl=0), send 16'h0523 -> frame_valid and wr_blocked in the same cycle, rdac stays 10'h200.
- Frame of 12 bits, then a frame of 18 bits -> frame_err pulse for each, no frame_valid, frame_data/rdac/ctrl unchanged. A following good 16'h1802 still decodes.
- Assert reset after 8 bits of 16'h0555 (ctrl was 2'b10, rdac 10'h123) -> rdac=10'h200, ctrl=0, no pulses. The next full 16'h1802 decodes normally.
- Back-to-back frames at minimum spacing (2 clk sync_n high, spi_clk phase 2 clk) -> every frame decoded. Check frame_valid latency equals SYNC_STAGES+2 from raw sync_n rise.

Source files
------------

// File: rtl/pot_spi_rx.sv
// SPI responder that decodes 16-bit digital-pot command frames (mode 0, MSB first)
// and models the pot's RDAC and control registers for loopback checking.
module pot_spi_rx #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [9:0] RDAC_RESET  = 10'h200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_clk,
  input  logic        sync_n,
  input  logic        din,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [15:0] frame_data,
  output logic [3:0]  cmd,
  output logic [9:0]  rdac,
  output logic [1:0]  ctrl,
  output logic        wr_blocked
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [SYNC_STAGES-1:0] sclk_s_q, sn_s_q, din_s_q;
  logic                   sclk_dly_q, sn_dly_q, din_dly_q;
  logic                   sclk_rise, sn_rise, sn_fall;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic        fv_q, fv_d, fe_q, fe_d, wb_q, wb_d;
  logic [15:0] fd_q, fd_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [9:0]  rdac_q, rdac_d;
  logic [1:0]  ctrl_q, ctrl_d;

  // sync_n chain resets low so a frame already open at reset release never
  // produces a falling edge; the block waits for the next clean fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s_q   <= '0;
      sn_s_q     <= '0;
      din_s_q    <= '0;
      sclk_dly_q <= 1'b0;
      sn_dly_q   <= 1'b0;
      din_dly_q  <= 1'b0;
    end else begin
      sclk_s_q   <= {sclk_s_q[SYNC_STAGES-2:0], spi_clk};
      sn_s_q     <= {sn_s_q[SYNC_STAGES-2:0], sync_n};
      din_s_q    <= {din_s_q[SYNC_STAGES-2:0], din};
      sclk_dly_q <= sclk_s_q[SYNC_STAGES-1];
      sn_dly_q   <= sn_s_q[SYNC_STAGES-1];
      din_dly_q  <= din_s_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_s_q[SYNC_STAGES-1] & ~sclk_dly_q;
  assign sn_rise   = sn_s_q[SYNC_STAGES-1] & ~sn_dly_q;
  assign sn_fall   = ~sn_s_q[SYNC_STAGES-1] & sn_dly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
      wb_q    <= 1'b0;
      fd_q    <= '0;
      cmd_q   <= '0;
      rdac_q  <= RDAC_RESET;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
      wb_q    <= wb_d;
      fd_q    <= fd_d;
      cmd_q   <= cmd_d;
      rdac_q  <= rdac_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    wb_d    = 1'b0;
    fd_d    = fd_q;
    cmd_d   = cmd_q;
    rdac_d  = rdac_q;
    ctrl_d  = ctrl_q;
    unique case (state_q)
      IDLE: begin
        if (sn_fall) begin
          cnt_d   = '0;
          shreg_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shreg_d = {shreg_q[14:0], din_dly_q};
          if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
        end
        if (sn_rise) state_d = CHECK;
      end
      CHECK: begin
        state_d = IDLE;
        if (cnt_q == 5'd16) begin
          fv_d  = 1'b1;
          fd_d  = shreg_q;
          cmd_d = shreg_q[13:10];
          // Frames with nonzero top bits still count as valid but touch nothing.
          if (shreg_q[15:14] == 2'b00) begin
            case (shreg_q[13:10])
              4'h1: begin
                if (ctrl_q[1]) rdac_d = shreg_q[9:0];
                else           wb_d   = 1'b1;
              end
              4'h4: begin
                rdac_d = RDAC_RESET;
                ctrl_d = '0;
              end
              4'h6:    ctrl_d = shreg_q[1:0];
              default: ;
            endcase
          end
        end else begin
          fe_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign wr_blocked  = wb_q;
  assign frame_data  = fd_q;
  assign cmd         = cmd_q;
  assign rdac        = rdac_q;
  assign ctrl        = ctrl_q;

endmodule

// File: tb/tb_pot_spi_rx.sv
// Randomized bench for pot_spi_rx: drives SPI frames and compares pulses and
// modelled pot registers against a frame-level reference model.
module tb_pot_spi_rx;
  localparam int         SS = 2;
  localparam logic [9:0] RR = 10'h200;

  logic        clk = 1'b0;
  logic        reset, spi_clk, sync_n, din;
  logic        frame_valid, frame_err, wr_blocked;
  logic [15:0] frame_data;
  logic [3:0]  cmd;
  logic [9:0]  rdac;
  logic [1:0]  ctrl;

  pot_spi_rx #(.SYNC_STAGES(SS), .RDAC_RESET(RR)) dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .sync_n(sync_n), .din(din),
    .frame_valid(frame_valid), .frame_err(frame_err), .frame_data(frame_data),
    .cmd(cmd), .rdac(rdac), .ctrl(ctrl), .wr_blocked(wr_blocked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor, sampled on the falling edge
  int fv_n = 0, fe_n = 0, wb_n = 0, wbfv_n = 0;
  int last_lat = 0, lat_min = 999, lat_max = 0;
  int rise_cyc = 0;
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_n++;
      last_lat = cyc - rise_cyc;
      if (last_lat < lat_min) lat_min = last_lat;
      if (last_lat > lat_max) lat_max = last_lat;
      if (wr_blocked) wbfv_n++;
    end
    if (frame_err)  fe_n++;
    if (wr_blocked) wb_n++;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // reference model: what the pot would hold after each frame
  int          e_fv = 0, e_fe = 0, e_wb = 0;
  logic [9:0]  m_rdac = RR;
  logic [1:0]  m_ctrl = 2'b00;
  logic [15:0] m_fd = 16'h0;
  logic [3:0]  m_cmd = 4'h0;

  task automatic model(input logic [15:0] f, input int n);
    if (n != 16) begin
      e_fe++;
    end else begin
      e_fv++;
      m_fd  = f;
      m_cmd = f[13:10];
      if (f[15:14] == 2'b00) begin
        if (f[13:10] == 4'h1) begin
          if (m_ctrl[1]) m_rdac = f[9:0];
          else e_wb++;
        end else if (f[13:10] == 4'h4) begin
          m_rdac = RR;
          m_ctrl = 2'b00;
        end else if (f[13:10] == 4'h6) begin
          m_ctrl = f[1:0];
        end
      end
    end
  endtask

  task automatic model_reset();
    m_rdac = RR; m_ctrl = 2'b00; m_fd = 16'h0; m_cmd = 4'h0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n bits of v, MSB first; rst_at >= 0 asserts reset before that bit's clock
  task automatic send(input logic [31:0] v, input int n, input int ph, input int gap,
                      input int rst_at);
    sync_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      din = v[n-1-i];
      wait_clk(ph);
      if (i == rst_at) begin
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
      end
      spi_clk = 1'b1;
      wait_clk(ph);
      spi_clk = 1'b0;
    end
    wait_clk(ph);
    sync_n   = 1'b1;
    rise_cyc = cyc;
    wait_clk(gap);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".fv"},   32'(fv_n),   32'(e_fv));
    check({tag, ".fe"},   32'(fe_n),   32'(e_fe));
    check({tag, ".wb"},   32'(wb_n),   32'(e_wb));
    check({tag, ".wbfv"}, 32'(wbfv_n), 32'(e_wb));
    check({tag, ".rdac"}, 32'(rdac),   32'(m_rdac));
    check({tag, ".ctrl"}, 32'(ctrl),   32'(m_ctrl));
    check({tag, ".fd"},   32'(frame_data), 32'(m_fd));
    check({tag, ".cmd"},  32'(cmd),    32'(m_cmd));
  endtask

  task automatic frame(input string tag, input logic [31:0] v, input int n);
    send(v, n, 2, 10, -1);
    model(v[15:0], n);
    check_all(tag);
    if (n == 16) check({tag, ".lat"}, 32'(last_lat), 32'(SS + 2));
  endtask

  initial begin
    reset = 1'b1; spi_clk = 1'b0; sync_n = 1'b1; din = 1'b0;
    wait_clk(4);
    check("rst.fv",   32'(frame_valid), 32'd0);
    check("rst.fe",   32'(frame_err),   32'd0);
    check("rst.wb",   32'(wr_blocked),  32'd0);
    check("rst.rdac", 32'(rdac), 32'(RR));
    check("rst.ctrl", 32'(ctrl), 32'd0);
    check("rst.fd",   32'(frame_data), 32'd0);
    check("rst.cmd",  32'(cmd), 32'd0);
    reset = 1'b0;
    wait_clk(3);

    frame("reset_cmd", 32'h1000, 16);
    frame("wr_ctrl",   32'h1802, 16);
    frame("wr_rdac",   32'h0523, 16);
    frame("wr_full",   32'h07FF, 16);
    frame("rdac_back", 32'h0523, 16);

    // partial frame cut by reset: nothing captured, registers back to reset
    send(32'h0555, 16, 2, 10, 8);
    model_reset();
    check_all("mid_rst");
    frame("post_rst", 32'h1802, 16);

    // write refused while ctrl[1]=0
    reset = 1'b1; wait_clk(2); reset = 1'b0; wait_clk(3);
    model_reset();
    frame("blocked", 32'h0523, 16);

    frame("short12",  32'h0ABC, 12);
    frame("long18",   32'h3FFFF, 18);
    frame("empty",    32'h0, 0);
    frame("after_err", 32'h1802, 16);
    frame("hi_bits",  32'hC523, 16);

    // back-to-back at minimum spacing
    for (int k = 0; k < 6; k++) begin
      logic [15:0] f;
      f = {2'b00, 4'h1, 10'($urandom)};
      send({16'h0, f}, 16, 2, 2, -1);
      model(f, 16);
    end
    wait_clk(10);
    check_all("b2b");
    check("b2b.lat_min", 32'(lat_min), 32'(SS + 2));
    check("b2b.lat_max", 32'(lat_max), 32'(SS + 2));

    for (int k = 0; k < 60; k++) begin
      logic [31:0] v;
      int          n, ph, gap, kind;
      kind = int'($urandom_range(0, 4));
      n    = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 20)) : 16;
      ph   = int'($urandom_range(2, 4));
      gap  = int'($urandom_range(2, 6));
      v    = $urandom;
      case (kind)
        0: v[15:0] = {2'b00, 4'h1, v[9:0]};
        1: v[15:0] = {2'b00, 4'h6, 8'h00, v[1:0]};
        2: v[15:0] = 16'h1000;
        3: ;
        default: v[15:10] = {2'b00, v[13:10]};
      endcase
      send(v, n, ph, gap, -1);
      wait_clk(8);
      model(v[15:0], n);
      check_all("rand");
      if (n == 16) check("rand.lat", 32'(last_lat), 32'(SS + 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
